// File: rtl/note_sequencer.sv
// note_sequencer
// Plays a table of notes into a pulse generator. Each entry holds a pitch
// control word, a duty word and a length in ticks. One tick is TICK_DIV clk
// cycles. A pitch word of 0 is a rest. A length of 0 ends the sequence.
//
// Optional build macro: NOTE_SEQ_GAP_EN. When it is defined, the sequencer
// inserts one silent tick (GAP) between consecutive non-final notes.
//
// Parameters
//   DEPTH     number of table entries (power of two)
//   TICK_DIV  clk cycles per duration tick
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   start, stop, loop   playback control (stop has the highest priority)
//   wr_en, wr_addr,
//   wr_ctrl, wr_duty,
//   wr_dur              table write port, accepted in every state
//   ctrl, duty          registered words to the pulse generator
//   busy                high in every state except IDLE
//   done                one-cycle pulse on normal (non-loop) completion
//   step_idx            index of the entry currently playing
module note_sequencer #(
  parameter  int DEPTH    = 16,
  parameter  int TICK_DIV = 100000,
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_ctrl,
  input  logic [31:0]      wr_duty,
  input  logic [15:0]      wr_dur,
  output logic [31:0]      ctrl,
  output logic [31:0]      duty,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_idx
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef NOTE_SEQ_GAP_EN
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, DONE} state_t;
`endif

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [15:0]     dur_cnt;
  logic [1:0]      rst_sync;
  logic            run_ok;

  // Reset release is passed through two flops so the FSM cannot leave IDLE
  // on a cycle where rst_n deasserts close to the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run_ok = rst_sync[1];

  // Note table: not reset. It is read at the LOAD edge, and the result is
  // latched into ctrl/duty/dur_cnt. A write to the same address on that edge
  // is therefore seen as old data (read-first).
  logic [31:0] ctrl_mem [DEPTH];
  logic [31:0] duty_mem [DEPTH];
  logic [15:0] dur_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctrl_mem[wr_addr] <= wr_ctrl;
      duty_mem[wr_addr] <= wr_duty;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  logic [31:0]      ld_ctrl;
  logic [31:0]      ld_duty;
  logic [15:0]      ld_dur;
  logic [IDX_W-1:0] next_idx;
  logic             last_idx;
  logic             tick_wrap;
  logic             loop_back;

  assign ld_ctrl   = ctrl_mem[step_idx];
  assign ld_duty   = duty_mem[step_idx];
  assign ld_dur    = dur_mem[step_idx];
  assign next_idx  = step_idx + 1'b1;
  assign last_idx  = (step_idx == IDX_W'(DEPTH - 1));
  assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
  // An empty table (end marker at index 0) must not spin forever in LOAD.
  assign loop_back = loop && (step_idx != '0);

`ifdef NOTE_SEQ_GAP_EN
  logic next_is_note;
  // Peek at the following entry so that no gap is inserted after the
  // final note.
  assign next_is_note = (dur_mem[next_idx] != 16'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctrl     <= '0;
      duty     <= '0;
      step_idx <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
    end else if (stop) begin
      state    <= IDLE;
      ctrl     <= '0;
      duty     <= '0;
      step_idx <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ctrl <= '0;
          duty <= '0;
          if (start && run_ok) begin
            state    <= LOAD;
            step_idx <= '0;
          end
        end

        LOAD: begin
          if (ld_dur == 16'd0) begin
            if (loop_back) begin
              state    <= LOAD;
              step_idx <= '0;
            end else begin
              state <= DONE;
            end
          end else begin
            state    <= PLAY;
            ctrl     <= ld_ctrl;
            // A rest drives both words to zero whatever duty was stored.
            duty     <= (ld_ctrl == 32'd0) ? 32'd0 : ld_duty;
            dur_cnt  <= ld_dur;
            tick_cnt <= '0;
          end
        end

        PLAY: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (dur_cnt == 16'd1) begin
              dur_cnt <= '0;
              ctrl    <= '0;
              duty    <= '0;
              if (last_idx) begin
                if (loop_back) begin
                  state    <= LOAD;
                  step_idx <= '0;
                end else begin
                  state <= DONE;
                end
              end else begin
                step_idx <= next_idx;
`ifdef NOTE_SEQ_GAP_EN
                state    <= next_is_note ? GAP : LOAD;
`else
                state    <= LOAD;
`endif
              end
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

`ifdef NOTE_SEQ_GAP_EN
        GAP: begin
          ctrl <= '0;
          duty <= '0;
          if (tick_wrap) begin
            tick_cnt <= '0;
            state    <= LOAD;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`endif

        DONE: begin
          state    <= IDLE;
          step_idx <= '0;
          ctrl     <= '0;
          duty     <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Directed test of note_sequencer with TICK_DIV=4 and DEPTH=16. Inputs are
// driven 1 ns after each rising edge, and outputs are sampled at the same
// point.
module tb_note_sequencer;
  localparam int DEPTH    = 16;
  localparam int TICK_DIV = 4;
`ifdef NOTE_SEQ_GAP_EN
  localparam int GAP_CYC  = TICK_DIV;
`else
  localparam int GAP_CYC  = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_ctrl;
  logic [31:0] wr_duty;
  logic [15:0] wr_dur;
  logic [31:0] ctrl;
  logic [31:0] duty;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;

  int total = 0;
  int bad   = 0;

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_ctrl(wr_ctrl), .wr_duty(wr_duty),
    .wr_dur(wr_dur), .ctrl(ctrl), .duty(duty), .busy(busy), .done(done),
    .step_idx(step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [31:0] c, input logic [31:0] dy,
                    input logic b, input logic d, input logic [3:0] i);
    chk({tag, ":ctrl"}, ctrl, c);
    chk({tag, ":duty"}, duty, dy);
    chk({tag, ":busy"}, 32'(busy), 32'(b));
    chk({tag, ":done"}, 32'(done), 32'(d));
    chk({tag, ":idx"},  32'(step_idx), 32'(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] c, input logic [31:0] dy, input logic [15:0] du);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_ctrl = c;
    wr_duty = dy;
    wr_dur  = du;
    step();
    wr_en   = 1'b0;
  endtask

  // Silent gap between two non-final notes (present only in the gap build).
  task automatic gap(input string tag, input logic [3:0] i);
    for (int g = 0; g < GAP_CYC; g++) begin
      step();
      st(tag, 32'h0, 32'h0, 1'b1, 1'b0, i);
    end
  endtask

  task automatic load_basic_table();
    wr(0, 32'h100, 32'h80, 16'd2);
    wr(1, 32'h200, 32'h40, 16'd1);
    wr(2, 32'h0,   32'h0,  16'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_ctrl = '0; wr_duty = '0; wr_dur = '0;

    // Reset state
    step();
    st("reset", 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    $display("txn reset: ctrl=0x%0h busy=%0b", ctrl, busy);
    rst_n = 1'b1;
    step(); step(); step();

    // Basic two-note sequence
    load_basic_table();
    start = 1'b1;
    step();
    start = 1'b0;
    st("t1_load0", 32'h0, 32'h0, 1'b1, 1'b0, 4'd0);
    for (int j = 0; j < 8; j++) begin
      start = (j == 3);            // start while busy must be ignored
      step();
      st("t1_note0", 32'h100, 32'h80, 1'b1, 1'b0, 4'd0);
    end
    start = 1'b0;
    gap("t1_gap", 4'd1);
    step();
    st("t1_load1", 32'h0, 32'h0, 1'b1, 1'b0, 4'd1);
    for (int j = 0; j < 4; j++) begin
      step();
      st("t1_note1", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    end
    step();
    st("t1_load2", 32'h0, 32'h0, 1'b1, 1'b0, 4'd2);
    step();
    st("t1_done", 32'h0, 32'h0, 1'b1, 1'b1, 4'd2);
    step();
    st("t1_idle", 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    $display("txn basic sequence: done=%0b busy=%0b", done, busy);

    // stop together with start resolves as stop
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stop_start:busy", 32'(busy), 32'h0);
    step();
    chk("stop_start_after:busy", 32'(busy), 32'h0);
    $display("txn stop+start: busy=%0b", busy);

    // Loop playback, then stop during the second note
    loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    st("t2_load0", 32'h0, 32'h0, 1'b1, 1'b0, 4'd0);
    for (int j = 0; j < 8; j++) begin
      step();
      st("t2_note0", 32'h100, 32'h80, 1'b1, 1'b0, 4'd0);
    end
    gap("t2_gap", 4'd1);
    step();
    st("t2_load1", 32'h0, 32'h0, 1'b1, 1'b0, 4'd1);
    for (int j = 0; j < 4; j++) begin
      step();
      st("t2_note1", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    end
    step();
    st("t2_load2", 32'h0, 32'h0, 1'b1, 1'b0, 4'd2);
    step();
    st("t2_wrap_load0", 32'h0, 32'h0, 1'b1, 1'b0, 4'd0);
    for (int j = 0; j < 8; j++) begin
      step();
      st("t2_rep_note0", 32'h100, 32'h80, 1'b1, 1'b0, 4'd0);
    end
    gap("t2_rep_gap", 4'd1);
    step();
    st("t2_rep_load1", 32'h0, 32'h0, 1'b1, 1'b0, 4'd1);
    step();
    st("t2_rep_note1", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    st("t2_stopped", 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    loop = 1'b0;
    $display("txn loop+stop: ctrl=0x%0h busy=%0b", ctrl, busy);

    // Empty table with loop set
    wr(0, 32'h100, 32'h80, 16'd0);
    loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    st("t3_load", 32'h0, 32'h0, 1'b1, 1'b0, 4'd0);
    step();
    st("t3_done", 32'h0, 32'h0, 1'b1, 1'b1, 4'd0);
    step();
    st("t3_idle", 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    loop = 1'b0;
    $display("txn empty table: busy=%0b", busy);

    // Full table, no end marker
    for (int i = 0; i < DEPTH; i++) wr(i, 32'h1000 + 32'(i), 32'(i + 1), 16'd1);
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      start = 1'b0;
      st("t4_load", 32'h0, 32'h0, 1'b1, 1'b0, 4'(i));
      for (int j = 0; j < TICK_DIV; j++) begin
        step();
        st("t4_note", 32'h1000 + 32'(i), 32'(i + 1), 1'b1, 1'b0, 4'(i));
      end
      if (i < DEPTH - 1) gap("t4_gap", 4'(i + 1));
    end
    step();
    st("t4_done", 32'h0, 32'h0, 1'b1, 1'b1, 4'd15);
    step();
    st("t4_idle", 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    $display("txn full table: idx=%0d busy=%0b", step_idx, busy);

    // Rewrite the playing entry, then asynchronous reset mid-note
    load_basic_table();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 8; j++) step();
    gap("t5_gap", 4'd1);
    step();
    st("t5_load1", 32'h0, 32'h0, 1'b1, 1'b0, 4'd1);
    step();
    st("t5_note1", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    wr(1, 32'h300, 32'h30, 16'd1);
    st("t5_wr_hold", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    step();
    st("t5_hold2", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    step();
    st("t5_hold3", 32'h200, 32'h40, 1'b1, 1'b0, 4'd1);
    step();
    st("t5_load2", 32'h0, 32'h0, 1'b1, 1'b0, 4'd2);
    step();
    st("t5_done", 32'h0, 32'h0, 1'b1, 1'b1, 4'd2);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 8; j++) step();
    gap("t5_gap2", 4'd1);
    step();
    step();
    st("t5_new_note1", 32'h300, 32'h30, 1'b1, 1'b0, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    st("t5_async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    $display("txn async reset: ctrl=0x%0h busy=%0b", ctrl, busy);
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    chk("rst_sync_hold:busy", 32'(busy), 32'h0);
    start = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
